// File: rtl/javk_fetch_if.sv
// Fetch-unit port bundle: memory read port, decode handshake, redirect control.
interface javk_fetch_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          redirect;
  logic [15:0]   redirect_pc;
  logic          bus_gnt;
  logic          mem_rd;
  logic [15:0]   mem_addr;
  logic [7:0]    mem_rdata;
  logic          out_valid;
  logic [7:0]    out_data;
  logic [15:0]   out_pc;
  logic          out_ready;
  logic [CW-1:0] q_count;

  modport master (
    input  redirect, redirect_pc, bus_gnt, mem_rdata, out_ready,
    output mem_rd, mem_addr, out_valid, out_data, out_pc, q_count
  );

  modport slave (
    output redirect, redirect_pc, bus_gnt, mem_rdata, out_ready,
    input  mem_rd, mem_addr, out_valid, out_data, out_pc, q_count
  );
endinterface

// File: rtl/javk_fetch.sv
// JAVK instruction prefetch: byte reads into a small address-tagged FIFO,
// drained by decode over valid/ready; redirect flushes and restarts fetch.
module javk_fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic          clk,
  input logic          rst,
  javk_fetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {FLUSH, RUN} state_t;

  state_t        state, state_nxt;
  logic [15:0]   fetch_pc, fetch_pc_nxt;
  logic          mem_rd_nxt;
  logic [15:0]   mem_addr_nxt;
  logic          inflight;
  logic [15:0]   rsp_addr;
  logic [PW-1:0] wr_ptr, rd_ptr, count;
  logic [AW-1:0] head;
  logic          issue_ok, push, pop, flush;

  logic [7:0]    data_q [DEPTH];
  logic [15:0]   pc_q   [DEPTH];

  assign count         = wr_ptr - rd_ptr;
  assign bus.q_count   = count;
  assign bus.out_valid = (count != '0);
  // When empty, point at the last popped slot so the outputs hold their value.
  assign head          = bus.out_valid ? rd_ptr[AW-1:0] : rd_ptr[AW-1:0] - AW'(1);
  assign bus.out_data  = data_q[head];
  assign bus.out_pc    = pc_q[head];

  // A read issued now lands two edges later, so both the response arriving this
  // cycle and the request on the bus right now must hold a free slot.
  assign issue_ok = bus.bus_gnt &&
                    ((int'(count) + int'(inflight) + int'(bus.mem_rd)) < DEPTH);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    mem_rd_nxt   = 1'b0;
    mem_addr_nxt = bus.mem_addr;
    push         = 1'b0;
    pop          = 1'b0;
    flush        = 1'b0;

    if (bus.redirect) begin
      state_nxt    = FLUSH;
      fetch_pc_nxt = bus.redirect_pc;
      flush        = 1'b1;
    end else begin
      if (state == FLUSH) begin
        state_nxt = RUN;
      end else begin
        push = inflight;
        pop  = bus.out_valid && bus.out_ready;
      end
      if (issue_ok) begin
        mem_rd_nxt   = 1'b1;
        mem_addr_nxt = fetch_pc;
        fetch_pc_nxt = fetch_pc + 16'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FLUSH;
      fetch_pc     <= RESET_PC;
      bus.mem_rd   <= 1'b0;
      bus.mem_addr <= '0;
      inflight     <= 1'b0;
      rsp_addr     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
    end else begin
      state        <= state_nxt;
      fetch_pc     <= fetch_pc_nxt;
      bus.mem_rd   <= mem_rd_nxt;
      bus.mem_addr <= mem_addr_nxt;
      inflight     <= bus.mem_rd;
      rsp_addr     <= bus.mem_addr;
      if (flush) begin
        wr_ptr <= rd_ptr;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // NOTE: the queue storage is reset because out_data/out_pc read it directly
  // and must show zero before the first byte arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (push && !flush) begin
      data_q[wr_ptr[AW-1:0]] <= bus.mem_rdata;
      pc_q[wr_ptr[AW-1:0]]   <= rsp_addr;
    end
  end
endmodule
